// File: rtl/fmps_pkt_tx.sv
// FMPS packet transmitter: queues per-FA-cycle status requests and sends each as a
// header + data AXI-Stream packet. Define FMPS_PKT_TX_DROP_COUNT_EN to add dropCount.
module fmps_pkt_tx #(
   parameter int          INDEX_WIDTH  = 5,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [15:0] HEADER_MAGIC = 16'hB6CF,
   parameter logic [15:0] DATA_MAGIC   = 16'hCACA
) (
   input  logic                          auClk,
   input  logic                          auResetN,
   input  logic                          auChannelUp,
   input  logic                          auFAstrobe,
   input  logic                          pktStrobe,
   input  logic [INDEX_WIDTH-1:0]        pktIndex,
   input  logic                          pktInvalidFMPS2CC,
   input  logic                          pktInvalidCC2CC,
   output logic [31:0]                   FMPS_TX_tdata,
   output logic                          FMPS_TX_tvalid,
   output logic                          FMPS_TX_tlast,
   input  logic                          FMPS_TX_tready,
   output logic [$clog2(FIFO_DEPTH):0]   queueCount,
   output logic                          txBusy,
   output logic [1:0]                    fsmState,
   output logic                          overflowSticky,
   input  logic                          overflowClear
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
   ,
   output logic [15:0]                   dropCount
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } state_t;

   typedef struct packed {
      logic [4:0] idx;
      logic       inv_fmps2cc;
      logic       inv_cc2cc;
      logic [7:0] cnt;
   } entry_t;

   function automatic logic [31:0] header_word(input entry_t e);
      return {HEADER_MAGIC, 1'b0, e.idx, 10'd0};
   endfunction

   function automatic logic [31:0] data_word(input entry_t e);
      return {e.inv_fmps2cc, e.inv_cc2cc, 1'b0, e.idx, DATA_MAGIC, e.cnt};
   endfunction

   state_t        state_q, state_d;
   logic [31:0]   tdata_q, tdata_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic [31:0]   data_word_q, data_word_d;
   logic [7:0]    cycle_cnt_q, cycle_cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          sticky_q, sticky_d;
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
   logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

   entry_t        fifo_mem [FIFO_DEPTH];
   entry_t        head;
   entry_t        push_entry;
   logic          pop;
   logic          push;
   logic          full;
   logic          overflow;

   // Stream handshake: a word transfers on a rising auClk edge where tvalid && tready.
   // Once tvalid is high, tdata/tlast/tvalid are frozen until that transfer happens.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 8'(auFAstrobe);
      head        = fifo_mem[rd_ptr_q];
      push_entry  = '{idx: 5'(pktIndex), inv_fmps2cc: pktInvalidFMPS2CC,
                      inv_cc2cc: pktInvalidCC2CC, cnt: cycle_cnt_d};
      pop         = 1'b0;
      state_d     = state_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      data_word_d = data_word_q;

      case (state_q)
         ST_IDLE: begin
            if (count_q != '0 && auChannelUp) begin
               pop         = 1'b1;
               state_d     = ST_HEADER;
               tvalid_d    = 1'b1;
               tlast_d     = 1'b0;
               tdata_d     = header_word(head);
               data_word_d = data_word(head);
            end
         end
         ST_HEADER: begin
            if (FMPS_TX_tready) begin
               state_d = ST_DATA;
               tdata_d = data_word_q;
               tlast_d = 1'b1;
            end
         end
         ST_DATA: begin
            if (FMPS_TX_tready) begin
               if (count_q != '0 && auChannelUp) begin
                  pop         = 1'b1;
                  state_d     = ST_HEADER;
                  tvalid_d    = 1'b1;
                  tlast_d     = 1'b0;
                  tdata_d     = header_word(head);
                  data_word_d = data_word(head);
               end else begin
                  state_d  = ST_IDLE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
         end
      endcase

      // A full queue still accepts a request when the same edge pops the head.
      full     = (count_q == CW'(FIFO_DEPTH));
      push     = pktStrobe && auChannelUp && (!full || pop);
      overflow = pktStrobe && auChannelUp && full && !pop;

      if (!auChannelUp) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         count_d  = count_q + CW'(push) - CW'(pop);
      end

      if (overflow)           sticky_d = 1'b1;
      else if (overflowClear) sticky_d = 1'b0;
      else                    sticky_d = sticky_q;

`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      if (overflowClear)
         drop_cnt_d = overflow ? 16'd1 : 16'd0;
      else if (overflow && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
      else
         drop_cnt_d = drop_cnt_q;
`endif
   end

   always_ff @(posedge auClk or negedge auResetN) begin
      if (!auResetN) begin
         state_q     <= ST_IDLE;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         data_word_q <= '0;
         cycle_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sticky_q    <= 1'b0;
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
         drop_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         data_word_q <= data_word_d;
         cycle_cnt_q <= cycle_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sticky_q    <= sticky_d;
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
         drop_cnt_q  <= drop_cnt_d;
`endif
      end
   end

   // Queue storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge auClk) begin
      if (push) fifo_mem[wr_ptr_q] <= push_entry;
   end

   assign FMPS_TX_tdata  = tdata_q;
   assign FMPS_TX_tvalid = tvalid_q;
   assign FMPS_TX_tlast  = tlast_q;
   assign queueCount     = count_q;
   assign txBusy         = (state_q != ST_IDLE);
   assign fsmState       = state_q;
   assign overflowSticky = sticky_q;
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
   assign dropCount      = drop_cnt_q;
`endif

   a_stream_stable: assert property (@(posedge auClk) disable iff (!auResetN)
      (FMPS_TX_tvalid && !FMPS_TX_tready) |=>
      (FMPS_TX_tvalid && $stable(FMPS_TX_tdata) && $stable(FMPS_TX_tlast)));

endmodule

// File: tb/tb_fmps_pkt_tx.sv
// Bench for fmps_pkt_tx: a queue-level reference model checked every cycle, plus
// directed packets whose words are worked out by hand.
module tb_fmps_pkt_tx;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [4:0] idx;
      logic       f;
      logic       c;
      logic [7:0] cnt;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          chan_up = 1'b1;
   logic          fa = 1'b0;
   logic          strobe = 1'b0;
   logic [4:0]    idx = '0;
   logic          inv_f = 1'b0;
   logic          inv_c = 1'b0;
   logic [31:0]   tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready = 1'b1;
   logic [CW-1:0] queue_count;
   logic          tx_busy;
   logic [1:0]    fsm_state;
   logic          sticky;
   logic          ov_clear = 1'b0;
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
   logic [15:0]   drop_count;
`endif

   int            n_cmp = 0;
   int            n_fail = 0;

   fmps_pkt_tx #(.INDEX_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
      .auClk             (clk),
      .auResetN          (rst_n),
      .auChannelUp       (chan_up),
      .auFAstrobe        (fa),
      .pktStrobe         (strobe),
      .pktIndex          (idx),
      .pktInvalidFMPS2CC (inv_f),
      .pktInvalidCC2CC   (inv_c),
      .FMPS_TX_tdata     (tdata),
      .FMPS_TX_tvalid    (tvalid),
      .FMPS_TX_tlast     (tlast),
      .FMPS_TX_tready    (tready),
      .queueCount        (queue_count),
      .txBusy            (tx_busy),
      .fsmState          (fsm_state),
      .overflowSticky    (sticky),
      .overflowClear     (ov_clear)
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      ,
      .dropCount         (drop_count)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   req_t        mq[$];
   req_t        m_cur;
   req_t        m_new;
   int          m_phase = 0;     // 0 nothing on the wire, 1 header, 2 data word
   logic [7:0]  m_cnt = '0;
   logic        m_sticky = 1'b0;
   logic [15:0] m_drop = '0;
   int          m_sz0;
   logic        m_pop;
   logic        m_ovf;

   function automatic logic [31:0] exp_hdr(input req_t r);
      return 32'hB6CF0000 | (32'(r.idx) << 10);
   endfunction

   function automatic logic [31:0] exp_dat(input req_t r);
      return (32'(r.f) << 31) | (32'(r.c) << 30) | (32'(r.idx) << 24) | 32'h00CACA00 | 32'(r.cnt);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_phase  = 0;
         m_cnt    = '0;
         m_sticky = 1'b0;
         m_drop   = '0;
      end else begin
         m_sz0 = mq.size();
         m_pop = 1'b0;
         m_ovf = 1'b0;
         m_cnt = m_cnt + 8'(fa);
         if (m_phase == 0) begin
            if (m_sz0 > 0 && chan_up) begin
               m_cur = mq.pop_front(); m_phase = 1; m_pop = 1'b1;
            end
         end else if (m_phase == 1) begin
            if (tready) m_phase = 2;
         end else if (tready) begin
            if (m_sz0 > 0 && chan_up) begin
               m_cur = mq.pop_front(); m_phase = 1; m_pop = 1'b1;
            end else begin
               m_phase = 0;
            end
         end
         if (strobe && chan_up) begin
            if (m_sz0 < DEPTH || m_pop) begin
               m_new.idx = idx; m_new.f = inv_f; m_new.c = inv_c; m_new.cnt = m_cnt;
               mq.push_back(m_new);
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (!chan_up) mq.delete();
         if (m_ovf) m_sticky = 1'b1;
         else if (ov_clear) m_sticky = 1'b0;
         if (ov_clear) m_drop = m_ovf ? 16'd1 : 16'd0;
         else if (m_ovf && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
   end

   // ---------------- compare process + scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] rx[$];
   logic        p_valid = 1'b0;
   logic        p_ready = 1'b0;
   logic        p_last = 1'b0;
   logic [31:0] p_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_valid = 1'b0;
      end else begin
         cmp("tvalid", 32'(tvalid), 32'(m_phase != 0));
         cmp("tlast", 32'(tlast), 32'(m_phase == 2));
         if (m_phase != 0)
            cmp("tdata", tdata, (m_phase == 1) ? exp_hdr(m_cur) : exp_dat(m_cur));
         cmp("queueCount", 32'(queue_count), 32'(mq.size()));
         cmp("txBusy", 32'(tx_busy), 32'(m_phase != 0));
         cmp("overflowSticky", 32'(sticky), 32'(m_sticky));
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
         cmp("dropCount", 32'(drop_count), 32'(m_drop));
`endif
         if (p_valid && !p_ready) begin
            cmp("hold_tvalid", 32'(tvalid), 32'd1);
            cmp("hold_tdata", tdata, p_data);
            cmp("hold_tlast", 32'(tlast), 32'(p_last));
         end
         p_valid = tvalid; p_ready = tready; p_data = tdata; p_last = tlast;
         if (tvalid && tready) rx.push_back(tdata);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while ((tx_busy || queue_count != '0) && n < max_cycles) begin
         tick();
         n++;
      end
      cmp("drain_done", 32'(!(tx_busy || queue_count != '0)), 32'd1);
   endtask

   task automatic send(input logic [4:0] i, input logic f, input logic c, input logic with_fa);
      strobe = 1'b1; idx = i; inv_f = f; inv_c = c; fa = with_fa;
      tick();
      strobe = 1'b0; inv_f = 1'b0; inv_c = 1'b0; fa = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_tvalid", 32'(tvalid), 32'd0);
      cmp("rst_tlast", 32'(tlast), 32'd0);
      cmp("rst_tdata", tdata, 32'd0);
      cmp("rst_queueCount", 32'(queue_count), 32'd0);
      cmp("rst_txBusy", 32'(tx_busy), 32'd0);
      cmp("rst_sticky", 32'(sticky), 32'd0);
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      cmp("rst_dropCount", 32'(drop_count), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // single packet: counter 1, index 5
      fa = 1'b1; tick(); fa = 1'b0;
      send(5'd5, 1'b0, 1'b0, 1'b0);
      cmp("lat_edge1_tvalid", 32'(tvalid), 32'd0);
      tick();
      cmp("lat_edge2_tvalid", 32'(tvalid), 32'd1);
      cmp("single_header", tdata, 32'hB6CF1400);
      cmp("single_header_tlast", 32'(tlast), 32'd0);
      tick();
      cmp("single_data", tdata, 32'h05CACA01);
      cmp("single_data_tlast", 32'(tlast), 32'd1);
      tick();
      cmp("single_idle", 32'(tvalid), 32'd0);

      // backpressure: indices 0..7, one FA strobe per 16-cycle slot
      rx.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(32'hB6CF0000 | (32'(i) << 10));
         exp_q.push_back(32'h00CACA00 | (32'(i) << 24) | 32'(1 + i));
         for (int c = 0; c < 16; c++) begin
            tready = 1'($urandom_range(0, 1));
            strobe = (c == 0);
            idx    = 5'(i);
            fa     = (c == 4);
            tick();
         end
      end
      strobe = 1'b0; fa = 1'b0; tready = 1'b1;
      wait_idle(100);
      cmp("bp_word_count", 32'(rx.size()), 32'd16);
      for (int k = 0; k < 16 && k < rx.size(); k++)
         cmp("bp_word", rx[k], exp_q[k]);

      // overflow: first request goes on the wire, next eight fill the queue
      tready = 1'b0;
      for (int i = 0; i < 9; i++) send(5'(i), 1'b0, 1'b0, 1'b0);
      cmp("ovf_full_count", 32'(queue_count), 32'd8);
      cmp("ovf_not_yet", 32'(sticky), 32'd0);
      send(5'd9, 1'b0, 1'b0, 1'b0);
      cmp("ovf_count_held", 32'(queue_count), 32'd8);
      cmp("ovf_sticky", 32'(sticky), 32'd1);
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      cmp("ovf_drop1", 32'(drop_count), 32'd1);
`endif
      ov_clear = 1'b1; tick(); ov_clear = 1'b0;
      cmp("ovf_cleared", 32'(sticky), 32'd0);
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      cmp("ovf_drop_cleared", 32'(drop_count), 32'd0);
`endif
      ov_clear = 1'b1;
      send(5'd10, 1'b0, 1'b0, 1'b0);
      ov_clear = 1'b0;
      cmp("ovf_set_wins", 32'(sticky), 32'd1);
`ifdef FMPS_PKT_TX_DROP_COUNT_EN
      cmp("ovf_drop_set_wins", 32'(drop_count), 32'd1);
`endif
      ov_clear = 1'b1; tick(); ov_clear = 1'b0;

      // push coincident with a pop at full queue
      tready = 1'b1;
      tick();
      cmp("full_in_data", 32'(tlast), 32'd1);
      send(5'd20, 1'b0, 1'b0, 1'b0);
      cmp("full_push_pop_count", 32'(queue_count), 32'd8);
      cmp("full_push_pop_sticky", 32'(sticky), 32'd0);
      wait_idle(100);

      // push coincident with FA strobe: counter 9 -> 10
      rx.delete();
      send(5'd9, 1'b0, 1'b1, 1'b1);
      wait_idle(20);
      cmp("fa_coinc_words", 32'(rx.size()), 32'd2);
      if (rx.size() == 2) cmp("fa_coinc_data", rx[1], 32'h49CACA0A);

      // channel drop while the data word is on the wire with 3 queued
      tready = 1'b0;
      for (int i = 1; i <= 4; i++) send(5'(i), 1'b0, 1'b0, 1'b0);
      cmp("chdn_queued", 32'(queue_count), 32'd3);
      tready = 1'b1; tick();
      cmp("chdn_in_data", 32'(tlast), 32'd1);
      tready = 1'b0; chan_up = 1'b0; strobe = 1'b1; idx = 5'd30;
      tick();
      cmp("chdn_flushed", 32'(queue_count), 32'd0);
      cmp("chdn_still_valid", 32'(tvalid), 32'd1);
      cmp("chdn_data_word", tdata, 32'h01CACA0A);
      tready = 1'b1; tick();
      cmp("chdn_done", 32'(tvalid), 32'd0);
      repeat (5) tick();
      strobe = 1'b0;
      cmp("chdn_no_tvalid", 32'(tvalid), 32'd0);
      cmp("chdn_no_ovf", 32'(sticky), 32'd0);
      chan_up = 1'b1; tick(); tick();
      cmp("chup_empty", 32'(tvalid), 32'd0);

      // counter wrap: 10 + 246 strobes = 256 -> 0
      fa = 1'b1; repeat (246) tick(); fa = 1'b0;
      rx.delete();
      send(5'd3, 1'b1, 1'b0, 1'b0);
      wait_idle(20);
      cmp("wrap_words", 32'(rx.size()), 32'd2);
      if (rx.size() == 2) begin
         cmp("wrap_header", rx[0], 32'hB6CF0C00);
         cmp("wrap_data", rx[1], 32'h83CACA00);
      end

      // reset in the middle of a header
      tready = 1'b0;
      send(5'd7, 1'b0, 1'b0, 1'b0);
      send(5'd8, 1'b0, 1'b0, 1'b0);
      cmp("prerst_tvalid", 32'(tvalid), 32'd1);
      cmp("prerst_count", 32'(queue_count), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      cmp("midrst_tvalid", 32'(tvalid), 32'd0);
      cmp("midrst_tlast", 32'(tlast), 32'd0);
      cmp("midrst_tdata", tdata, 32'd0);
      cmp("midrst_count", 32'(queue_count), 32'd0);
      cmp("midrst_busy", 32'(tx_busy), 32'd0);
      cmp("midrst_sticky", 32'(sticky), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      tready = 1'b1;
      repeat (3) tick();
      cmp("postrst_idle", 32'(tvalid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

endmodule
